// File: rtl/msb_pkg.sv
// Shared types and widths for the MSB position encoder/decoder pair.
// Latency: none (declarations only).
// Backpressure: n/a.
package msb_pkg;

    localparam int VEC_W = 8;
    localparam int POS_W = 3;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/pos_to_onehot.sv
// Bit position to one-hot vector.
// Latency: combinational.
// Backpressure: n/a.
module pos_to_onehot
    import msb_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    output logic [VEC_W-1:0] onehot
);

    assign onehot = VEC_W'(1) << pos;

endmodule

// File: rtl/msb_pos_decoder.sv
// Rebuilds an 8-bit vector from a frame of descending bit positions.
// Latency: result valid the cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result is held awaiting out_ready.
module msb_pos_decoder
    import msb_pkg::*;
#(
    parameter int MAX_POS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] prev_q, prev_d;

    logic [VEC_W-1:0] pos_onehot;
    logic             accept;
    logic             first_beat;
    logic             overflow;
    logic             order_bad;
    logic             legal;

    pos_to_onehot u_pos_to_onehot (
        .pos    (in_pos),
        .onehot (pos_onehot)
    );

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_vec   = vec_q;
    assign out_cnt   = cnt_q;
    assign out_err   = err_q;

    assign accept     = in_valid && in_ready;
    // prev_q is meaningless before the first beat, so ordering is only checked afterwards.
    assign first_beat = (state_q == ST_IDLE);
    assign overflow   = (cnt_q == CNT_W'(MAX_POS));
    assign order_bad  = !first_beat && (in_pos >= prev_q);
    assign legal      = !overflow && !order_bad;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        prev_d  = prev_q;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    if (legal) begin
                        vec_d  = vec_q | pos_onehot;
                        cnt_d  = cnt_q + CNT_W'(1);
                        prev_d = in_pos;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = in_last ? ST_HOLD : ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    prev_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                prev_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: tb/tb_msb_pos_decoder.sv
// Directed bench for msb_pos_decoder with a result scoreboard.
module tb_msb_pos_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_pos;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_vec;
    logic [1:0] out_cnt;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    typedef struct packed {
        logic [7:0] vec;
        logic [1:0] cnt;
        logic       err;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    msb_pos_decoder #(.MAX_POS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pos    (in_pos),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_cnt   (out_cnt),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] vec, input logic [1:0] cnt, input logic err);
        res_t r;
        r.vec = vec;
        r.cnt = cnt;
        r.err = err;
        sb.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic beat(input logic [2:0] pos, input logic last, input int gap);
        repeat (gap) begin
            in_pos = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        check("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_pos   = pos;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic result(input int hold_cycles);
        res_t exp;
        int   waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout observed out_valid=0 expected=1");
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=result expected=none");
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i <= hold_cycles; i++) begin
            check("out_vec", 32'(out_vec), 32'(exp.vec));
            check("out_cnt", 32'(out_cnt), 32'(exp.cnt));
            check("out_err", 32'(out_err), 32'(exp.err));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            if (i < hold_cycles) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_out_valid", 32'(out_valid), 32'd0);
        check("consumed_in_ready", 32'(in_ready), 32'd1);
        check("consumed_vec_clear", 32'(out_vec), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_pos    = 3'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_vec", 32'(out_vec), 32'd0);
        check("reset_out_cnt", 32'(out_cnt), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Basic three-beat frame.
        push(8'b1001_0010, 2'd3, 1'b0);
        beat(3'd7, 1'b0, 0);
        check("no_early_valid", 32'(out_valid), 32'd0);
        beat(3'd4, 1'b0, 0);
        beat(3'd1, 1'b1, 0);
        result(0);

        // Back-to-back frames of decreasing length.
        push(8'b0011_1000, 2'd3, 1'b0);
        beat(3'd5, 1'b0, 0);
        beat(3'd4, 1'b0, 0);
        beat(3'd3, 1'b1, 0);
        result(0);
        push(8'b0000_1010, 2'd2, 1'b0);
        beat(3'd3, 1'b0, 0);
        beat(3'd1, 1'b1, 0);
        result(0);
        push(8'b0000_1000, 2'd1, 1'b0);
        beat(3'd3, 1'b1, 0);
        result(0);

        // Order violation, overflow, and an equal position.
        push(8'b0000_0101, 2'd2, 1'b1);
        beat(3'd2, 1'b0, 0);
        beat(3'd5, 1'b0, 0);
        beat(3'd0, 1'b1, 0);
        result(0);
        push(8'b1110_0000, 2'd3, 1'b1);
        beat(3'd7, 1'b0, 0);
        beat(3'd6, 1'b0, 0);
        beat(3'd5, 1'b0, 0);
        beat(3'd4, 1'b1, 0);
        result(0);
        push(8'b0000_1000, 2'd1, 1'b1);
        beat(3'd3, 1'b0, 0);
        beat(3'd3, 1'b1, 0);
        result(0);

        // Position 0 as a legal first beat.
        push(8'b0000_0001, 2'd1, 1'b0);
        beat(3'd0, 1'b1, 0);
        result(0);

        // Held result under backpressure, then immediate next frame.
        push(8'b0100_0001, 2'd2, 1'b0);
        beat(3'd6, 1'b0, 0);
        beat(3'd0, 1'b1, 0);
        result(5);
        push(8'b0000_0100, 2'd1, 1'b0);
        beat(3'd2, 1'b1, 0);
        result(0);

        // Reset mid-frame leaves no residue.
        beat(3'd6, 1'b0, 0);
        beat(3'd2, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("midrst_out_vec", 32'(out_vec), 32'd0);
        check("midrst_out_cnt", 32'(out_cnt), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(8'b0001_0000, 2'd1, 1'b0);
        beat(3'd4, 1'b1, 0);
        result(0);

        // Reset while holding an errored result.
        beat(3'd1, 1'b0, 0);
        beat(3'd5, 1'b1, 0);
        rst = 1'b1;
        #1;
        check("holdrst_out_valid", 32'(out_valid), 32'd0);
        check("holdrst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(8'b0010_0000, 2'd1, 1'b0);
        beat(3'd5, 1'b1, 0);
        result(0);

        // Gapped beats match the back-to-back result.
        push(8'b1001_0010, 2'd3, 1'b0);
        beat(3'd7, 1'b0, 2);
        beat(3'd4, 1'b0, 3);
        beat(3'd1, 1'b1, 1);
        result(0);

        // out_ready held high while collecting has no effect.
        out_ready = 1'b1;
        push(8'b1000_0100, 2'd2, 1'b0);
        beat(3'd7, 1'b0, 1);
        check("ready_high_collect", 32'(out_valid), 32'd0);
        beat(3'd2, 1'b1, 0);
        result(0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/msb_pos_decoder.md
MSB_POS_DECODER -- requirements
Module: msb_pos_decoder

Interface
REQ-001 SHALL have parameter: MAX_POS, default 3, max positions per frame (legal 1..3).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_pos  input  3  bit position (0..7) of one set bit.
REQ-005 SHALL have port: in_valid  input  1  in_pos/in_last valid.
REQ-006 SHALL have port: in_last  input  1  beat closes the frame.
REQ-007 SHALL have port: in_ready  output  1  decoder accepts a beat.
REQ-008 SHALL have port: out_vec  output  8  reconstructed vector.
REQ-009 SHALL have port: out_cnt  output  2  positions placed into out_vec.
REQ-010 SHALL have port: out_err  output  1  frame had an order or overflow violation.
REQ-011 SHALL have port: out_valid  output  1  out_vec/out_cnt/out_err valid.
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.

Function
REQ-013 SHALL be the inverse of the top-3-MSB position encoder: a frame of positions, highest first, rebuilds the 8-bit vector.
REQ-014 SHALL accept a beat only when in_valid and in_ready are both 1 at a rising edge.
REQ-015 SHALL implement states IDLE (nothing collected), COLLECT (>=1 beat accepted), HOLD (result presented).
REQ-016 SHALL drive in_ready = 1 in IDLE and COLLECT and 0 in HOLD; there is no bypass from HOLD.
REQ-017 SHALL transition IDLE -> COLLECT on an accepted beat with in_last=0, and IDLE -> HOLD on an accepted beat with in_last=1.
REQ-018 SHALL stay in COLLECT on an accepted beat with in_last=0, and go COLLECT -> HOLD on an accepted beat with in_last=1.
REQ-019 SHALL go HOLD -> IDLE on out_valid and out_ready both 1, and clear vec, cnt, err and the previous-position register on that edge.
REQ-020 SHALL apply a legal beat as follows: set bit in_pos of vec, increment cnt, and store in_pos as the previous position.
REQ-021 SHALL treat the first beat of a frame as legal whenever cnt < MAX_POS.
REQ-022 SHALL treat a later beat as legal only if in_pos < previous position (strictly descending).
REQ-023 SHALL discard a beat with in_pos >= previous position (vec and cnt unchanged) and set err.
REQ-024 SHALL discard a beat accepted when cnt == MAX_POS and set err.
REQ-025 SHALL keep err sticky until the frame is consumed.
REQ-026 SHALL still close the frame on a discarded beat that carries in_last=1.
REQ-027 SHALL drive out_valid = 1 exactly in HOLD, asserted the cycle after the in_last beat is accepted (latency 1).
REQ-028 SHALL register out_vec, out_cnt and out_err, and hold them stable throughout HOLD.
REQ-029 SHALL tolerate out_ready held high in IDLE/COLLECT with no effect.

Reset
REQ-030 SHALL, while rst=1, immediately force state IDLE, out_vec=0, out_cnt=0, out_err=0, out_valid=0, and clear the previous-position register.
REQ-031 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
REQ-032 SHALL discard a partial frame on reset mid-frame or during HOLD, with no residue in the next frame.

Structure
REQ-033 SHALL take the state enumeration, VEC_W=8 and POS_W=3 from shared package msb_pkg, alongside the encoder.
REQ-034 SHALL use one sub-module, pos_to_onehot (3-bit position -> 8-bit one-hot, combinational), OR-ed into vec.

Verification
REQ-035 SHALL cover: beats 7, 4, 1(last) -> out_vec=1001_0010, out_cnt=3, out_err=0, out_valid the cycle after beat 3.
REQ-036 SHALL cover: beats 5, 4, 3(last) -> out_vec=0011_1000, cnt=3; then 3, 1(last) -> 0000_1010, cnt=2; then 3(last) -> 0000_1000, cnt=1.
REQ-037 SHALL cover: beats 2, 5, 0(last) -> out_vec=0000_0101, cnt=2, err=1; beats 7, 6, 5, 4(last) -> out_vec=1110_0000, cnt=3, err=1.
REQ-038 SHALL cover: out_ready=0 for 5 cycles in HOLD -> out_valid=1, in_ready=0, outputs stable; out_ready=1 -> IDLE next cycle and next frame accepted.
REQ-039 SHALL cover: rst pulsed after beats 6, 2 -> outputs zero during rst; next frame 4(last) -> out_vec=0001_0000, cnt=1, err=0.
REQ-040 SHALL cover: in_valid toggled with gaps between beats -> same result as back-to-back beats.
